bauturi_controller: RTL

//  Credit/sequencing controller for the drinks vending machine. Accumulates 1-leu and 5-lei coin pulses
//  and, once credit reaches PRICE, requests one brew from the dispenser over a req/done handshake.

---
 rtl/bauturi_controller.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/bauturi_controller.sv
// bauturi_controller
// Credit and sequencing controller for the drinks vending machine. It adds up
// 1-leu and 5-lei coin pulses. When the credit reaches PRICE it requests one
// brew from the dispenser, then pays back the change one leu at a time
// through the coin hopper.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   b1leu         1-cycle pulse: one leu inserted
//   b5lei         1-cycle pulse: five lei inserted
//   cancel        level: refund the whole credit
//   brew_done     1-cycle pulse: dispenser finished
//   hopper_ready  hopper can eject a coin this cycle
//   brew_req      held high while a brew is requested
//   rest          1-cycle pulse: eject one 1-leu coin
//   coin_reject   1-cycle pulse: coin sampled but not credited
//   fault         1-cycle pulse: brew timed out
//   busy          high in BREW and CHANGE
//   credit        current credit
//
// state   | meaning
// COLLECT | accept coins, wait for price or cancel
// BREW    | brew_req held, waiting for brew_done or timeout
// CHANGE  | pay the remaining credit back one leu per rest pulse
module bauturi_controller #(
  parameter int PRICE        = 2,
  parameter int CREDIT_W     = 4,
  parameter int MAX_CREDIT   = 15,
  parameter int BREW_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                b1leu,
  input  logic                b5lei,
  input  logic                cancel,
  input  logic                brew_done,
  input  logic                hopper_ready,
  output logic                brew_req,
  output logic                rest,
  output logic                coin_reject,
  output logic                fault,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  // The sum is computed three bits wider than the credit so that credit plus
  // the largest coin (6) cannot wrap before the overflow compare.
  localparam int SUM_W = CREDIT_W + 3;
  localparam int TMR_W = (BREW_TIMEOUT > 1) ? $clog2(BREW_TIMEOUT + 1) : 1;
  localparam logic [SUM_W-1:0] MAX_S   = SUM_W'(MAX_CREDIT);
  localparam logic [SUM_W-1:0] PRICE_S = SUM_W'(PRICE);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(BREW_TIMEOUT - 1);

  typedef enum logic [1:0] {COLLECT, BREW, CHANGE} state_t;

  state_t              state, state_nxt;
  logic [CREDIT_W-1:0] credit_nxt;
  logic [TMR_W-1:0]    timer, timer_nxt;
  logic                brew_req_nxt, rest_nxt, reject_nxt, fault_nxt;
  logic [SUM_W-1:0]    coin, sum, nxt;
  logic                coin_in;

  assign coin_in = b1leu | b5lei;
  assign coin    = SUM_W'(b1leu) + (b5lei ? SUM_W'(5) : '0);
  assign sum     = SUM_W'(credit) + coin;

  always_comb begin
    state_nxt    = state;
    credit_nxt   = credit;
    timer_nxt    = timer;
    brew_req_nxt = 1'b0;
    rest_nxt     = 1'b0;
    reject_nxt   = 1'b0;
    fault_nxt    = 1'b0;
    nxt          = SUM_W'(credit);
    case (state)
      COLLECT: begin
        // An overflowing coin is returned. The cancel decision in the same
        // cycle then uses the unchanged credit.
        if (sum > MAX_S) reject_nxt = coin_in;
        else             nxt = sum;
        if (nxt >= PRICE_S) begin
          state_nxt    = BREW;
          credit_nxt   = CREDIT_W'(nxt - PRICE_S);
          brew_req_nxt = 1'b1;
          timer_nxt    = TMR_LOAD;
        end else if (cancel && (nxt != '0)) begin
          state_nxt  = CHANGE;
          credit_nxt = CREDIT_W'(nxt);
        end else begin
          credit_nxt = CREDIT_W'(nxt);
        end
      end
      BREW: begin
        reject_nxt   = coin_in;
        brew_req_nxt = 1'b1;
        if (brew_done) begin
          brew_req_nxt = 1'b0;
          state_nxt    = (credit != '0) ? CHANGE : COLLECT;
        end else if (timer == '0) begin
          // The brew never happened, so the price goes back on the credit
          // and the whole amount is refunded.
          brew_req_nxt = 1'b0;
          fault_nxt    = 1'b1;
          credit_nxt   = CREDIT_W'(SUM_W'(credit) + PRICE_S);
          state_nxt    = CHANGE;
        end else begin
          timer_nxt = timer - TMR_W'(1);
        end
      end
      CHANGE: begin
        reject_nxt = coin_in;
        if (credit == '0) begin
          state_nxt = COLLECT;
        end else if (hopper_ready && !rest) begin
          // Looking at the previous rest output keeps pulses at least
          // two cycles apart.
          rest_nxt   = 1'b1;
          credit_nxt = credit - CREDIT_W'(1);
        end
      end
      default: state_nxt = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= COLLECT;
      credit      <= '0;
      timer       <= '0;
      brew_req    <= 1'b0;
      rest        <= 1'b0;
      coin_reject <= 1'b0;
      fault       <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      credit      <= credit_nxt;
      timer       <= timer_nxt;
      brew_req    <= brew_req_nxt;
      rest        <= rest_nxt;
      coin_reject <= reject_nxt;
      fault       <= fault_nxt;
      busy        <= (state_nxt != COLLECT);
    end
  end

endmodule
